// File: rtl/x2050_mpx_pkg.sv
// Shared definitions for the 2050 multiplexor channel models: status, command
// and sense encodings, the control-unit state encoding and bus parity.
package x2050_mpx_pkg;

    localparam logic [7:0] STS_ATTN = 8'h80;
    localparam logic [7:0] STS_SM   = 8'h40;
    localparam logic [7:0] STS_CUE  = 8'h20;
    localparam logic [7:0] STS_BUSY = 8'h10;
    localparam logic [7:0] STS_CE   = 8'h08;
    localparam logic [7:0] STS_DE   = 8'h04;
    localparam logic [7:0] STS_UC   = 8'h02;
    localparam logic [7:0] STS_UE   = 8'h01;
    localparam logic [7:0] STS_END  = STS_CE | STS_DE;
    localparam logic [7:0] STS_ERR  = STS_UC | STS_CE | STS_DE;

    localparam logic [7:0] CMD_WRITE   = 8'h01;
    localparam logic [7:0] CMD_READ    = 8'h02;
    localparam logic [7:0] CMD_CONTROL = 8'h03;
    localparam logic [7:0] CMD_SENSE   = 8'h04;

    localparam logic [7:0] SNS_CMD_REJ = 8'h80;
    localparam logic [7:0] SNS_INT_REQ = 8'h40;
    localparam logic [7:0] SNS_BUS_OUT = 8'h20;
    localparam logic [7:0] SNS_EQUIP   = 8'h10;
    localparam logic [7:0] SNS_DATA    = 8'h08;
    localparam logic [7:0] SNS_OVERRUN = 8'h04;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_PASS       = 4'd1,
        S_ADDR_IN    = 4'd2,
        S_CMD        = 4'd3,
        S_ISTAT      = 4'd4,
        S_ISTAT_WAIT = 4'd5,
        S_DATA       = 4'd6,
        S_DATA_WAIT  = 4'd7,
        S_STOP_WAIT  = 4'd8,
        S_ESTAT      = 4'd9
    } mpx_state_e;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/x2050mpxcu_buf.sv
// Device data buffer: BUF_DEPTH bytes, synchronous write, asynchronous read,
// reseeded with DATA_SEED + index on reset.
module x2050mpxcu_buf #(
    parameter int         BUF_DEPTH = 16,
    parameter logic [7:0] DATA_SEED = 8'h40,
    localparam int        AW        = $clog2(BUF_DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [BUF_DEPTH];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= DATA_SEED + 8'(i);
            end
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/x2050mpxcu.sv
// Single-device control unit on the 2050 multiplexor interface: selection,
// burst data transfer, ending status and status stacking for one address.
module x2050mpxcu
    import x2050_mpx_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR  = 8'h0E,
    parameter int         BUF_DEPTH = 16,
    parameter logic [7:0] DATA_SEED = 8'h40
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [8:0] i_mpx_bus_out,
    input  logic       i_mpx_operational_out,
    input  logic       i_mpx_select_out,
    input  logic       i_mpx_hold_out,
    input  logic       i_mpx_address_out,
    input  logic       i_mpx_command_out,
    input  logic       i_mpx_service_out,
    input  logic       i_mpx_suppress_out,
    output logic [8:0] o_mpx_bus_in,
    output logic       o_mpx_operational_in,
    output logic       o_mpx_select_in,
    output logic       o_mpx_address_in,
    output logic       o_mpx_status_in,
    output logic       o_mpx_service_in,
    output logic       o_mpx_request_in,
    output logic       o_mpx_data_in,
    output logic       o_mpx_disc_in,
    output logic [3:0] o_state,
    output logic [7:0] o_sense
);

    localparam int          AW       = $clog2(BUF_DEPTH);
    localparam logic [AW:0] FULL_CNT = BUF_DEPTH[AW:0];

    mpx_state_e  r_state;
    logic        r_opl_in, r_sel_in, r_addr_in, r_sta_in, r_svc_in, r_req_in;
    logic        r_pending, r_busy, r_poll, r_err;
    logic [7:0]  r_cmd, r_status, r_stack, r_sense;
    logic [AW:0] r_count;

    logic        w_sel_me, w_bad_par, w_cmd_ok, w_bad_cmd, w_we, w_step, w_abort, w_drive;
    logic [7:0]  w_rd_data, w_byte;
    logic [AW:0] w_limit;
    logic        w_unused;

    assign w_unused  = i_mpx_suppress_out;
    assign w_sel_me  = i_mpx_select_out & i_mpx_address_out & (i_mpx_bus_out[7:0] == DEV_ADDR);
    assign w_bad_par = ~^i_mpx_bus_out;
    assign w_cmd_ok  = (i_mpx_bus_out[7:0] >= CMD_WRITE) & (i_mpx_bus_out[7:0] <= CMD_SENSE);
    assign w_bad_cmd = w_bad_par | ~w_cmd_ok;
    assign w_limit   = (r_cmd == CMD_SENSE) ? {{AW{1'b0}}, 1'b1} : FULL_CNT;
    assign w_we      = (r_state == S_DATA) & i_mpx_service_out & i_mpx_operational_out
                       & (r_cmd == CMD_WRITE);

    x2050mpxcu_buf #(
        .BUF_DEPTH (BUF_DEPTH),
        .DATA_SEED (DATA_SEED)
    ) u_buf (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_we    (w_we),
        .i_addr  (r_count[AW-1:0]),
        .i_wdata (i_mpx_bus_out[7:0]),
        .o_rdata (w_rd_data)
    );

    // A normal handshake step in the current state takes priority over an abort.
    always_comb begin
        case (r_state)
            S_ADDR_IN:    w_step = i_mpx_command_out & ~i_mpx_address_out;
            S_CMD:        w_step = ~i_mpx_command_out;
            S_ISTAT:      w_step = i_mpx_service_out | i_mpx_command_out;
            S_ISTAT_WAIT: w_step = ~i_mpx_service_out;
            S_DATA:       w_step = i_mpx_service_out | i_mpx_command_out;
            S_DATA_WAIT:  w_step = ~i_mpx_service_out;
            S_STOP_WAIT:  w_step = ~i_mpx_command_out;
            S_ESTAT:      w_step = i_mpx_service_out | i_mpx_command_out;
            default:      w_step = 1'b1;
        endcase
    end

    assign w_abort = ~i_mpx_select_out & ~i_mpx_hold_out & ~w_step;

    // Byte presented on bus-in for the current state.
    always_comb begin
        case (r_state)
            S_ADDR_IN:        w_byte = DEV_ADDR;
            S_ISTAT, S_ESTAT: w_byte = r_status;
            S_DATA:           w_byte = (r_cmd == CMD_SENSE) ? r_sense : w_rd_data;
            default:          w_byte = 8'h00;
        endcase
    end

    assign w_drive      = r_addr_in | r_sta_in | (r_svc_in & (r_cmd != CMD_WRITE));
    assign o_mpx_bus_in = w_drive ? {odd_parity(w_byte), w_byte} : 9'h000;

    // Sequencer: state, in-tags and command context.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            {r_opl_in, r_sel_in, r_addr_in, r_sta_in, r_svc_in, r_req_in} <= 6'b000000;
            {r_pending, r_busy, r_poll, r_err} <= 4'b0000;
            r_cmd    <= 8'h00;
            r_status <= 8'h00;
            r_stack  <= 8'h00;
            r_sense  <= 8'h00;
            r_count  <= '0;
        end else if (!i_mpx_operational_out) begin
            r_state  <= S_IDLE;
            {r_opl_in, r_sel_in, r_addr_in, r_sta_in, r_svc_in, r_req_in} <= 6'b000000;
            {r_pending, r_busy, r_poll, r_err} <= 4'b0000;
            r_cmd    <= 8'h00;
            r_status <= 8'h00;
            r_stack  <= 8'h00;
            r_sense  <= 8'h00;
            r_count  <= '0;
        end else if (w_abort) begin
            r_state <= S_IDLE;
            {r_opl_in, r_sel_in, r_addr_in, r_sta_in, r_svc_in, r_req_in} <= 6'b000000;
        end else begin
            r_req_in <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_req_in <= r_pending;
                    if (w_sel_me) begin
                        r_state   <= S_ADDR_IN;
                        r_opl_in  <= 1'b1;
                        r_addr_in <= 1'b1;
                        r_busy    <= r_pending;
                        r_poll    <= 1'b0;
                        r_req_in  <= 1'b0;
                    end else if (i_mpx_select_out && !i_mpx_address_out && r_pending) begin
                        r_state   <= S_ADDR_IN;
                        r_opl_in  <= 1'b1;
                        r_addr_in <= 1'b1;
                        r_busy    <= 1'b0;
                        r_poll    <= 1'b1;
                        r_req_in  <= 1'b0;
                    end else if (i_mpx_select_out) begin
                        r_state  <= S_PASS;
                        r_sel_in <= 1'b1;
                        r_req_in <= 1'b0;
                    end
                end
                S_PASS: if (!i_mpx_select_out) begin
                    r_state  <= S_IDLE;
                    r_sel_in <= 1'b0;
                end
                S_ADDR_IN: if (w_step) begin
                    r_state   <= S_CMD;
                    r_addr_in <= 1'b0;
                    if (r_busy) begin
                        r_status <= STS_BUSY;
                    end else if (!r_poll) begin
                        r_cmd    <= i_mpx_bus_out[7:0];
                        r_err    <= w_bad_cmd;
                        r_status <= w_bad_cmd ? STS_ERR : 8'h00;
                        if (w_bad_par) begin
                            r_sense <= SNS_BUS_OUT;
                        end else if (!w_cmd_ok) begin
                            r_sense <= SNS_CMD_REJ;
                        end
                    end
                end
                S_CMD: if (w_step) begin
                    r_sta_in <= 1'b1;
                    if (r_poll) begin
                        r_state  <= S_ESTAT;
                        r_status <= r_stack;
                    end else begin
                        r_state <= S_ISTAT;
                    end
                end
                S_ISTAT: if (i_mpx_service_out) begin
                    r_state  <= S_ISTAT_WAIT;
                    r_sta_in <= 1'b0;
                end else if (i_mpx_command_out) begin
                    // Initial status stacked; a busy reply leaves the original stack alone.
                    r_state  <= S_IDLE;
                    r_sta_in <= 1'b0;
                    r_opl_in <= 1'b0;
                    if (!r_busy) begin
                        r_pending <= 1'b1;
                        r_stack   <= r_status;
                    end
                end
                S_ISTAT_WAIT: if (w_step) begin
                    if (r_busy || r_err || r_cmd == CMD_CONTROL) begin
                        r_state  <= S_IDLE;
                        r_opl_in <= 1'b0;
                    end else begin
                        r_state  <= S_DATA;
                        r_svc_in <= 1'b1;
                        r_count  <= '0;
                    end
                end
                S_DATA: if (i_mpx_service_out) begin
                    r_state  <= S_DATA_WAIT;
                    r_svc_in <= 1'b0;
                    r_count  <= r_count + 1'b1;
                end else if (i_mpx_command_out) begin
                    r_state  <= S_STOP_WAIT;
                    r_svc_in <= 1'b0;
                end
                S_DATA_WAIT: if (w_step) begin
                    if (r_count == w_limit) begin
                        r_state  <= S_ESTAT;
                        r_sta_in <= 1'b1;
                        r_status <= r_err ? STS_ERR : STS_END;
                    end else begin
                        r_state  <= S_DATA;
                        r_svc_in <= 1'b1;
                    end
                end
                S_STOP_WAIT: if (w_step) begin
                    r_state  <= S_ESTAT;
                    r_sta_in <= 1'b1;
                    r_status <= r_err ? STS_ERR : STS_END;
                end
                S_ESTAT: if (i_mpx_service_out) begin
                    r_state   <= S_IDLE;
                    r_sta_in  <= 1'b0;
                    r_opl_in  <= 1'b0;
                    r_pending <= 1'b0;
                    if (r_cmd == CMD_SENSE && !r_err) begin
                        r_sense <= 8'h00;
                    end
                end else if (i_mpx_command_out) begin
                    r_state   <= S_IDLE;
                    r_sta_in  <= 1'b0;
                    r_opl_in  <= 1'b0;
                    r_pending <= 1'b1;
                    r_stack   <= r_status;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_mpx_operational_in = r_opl_in;
    assign o_mpx_select_in      = r_sel_in;
    assign o_mpx_address_in     = r_addr_in;
    assign o_mpx_status_in      = r_sta_in;
    assign o_mpx_service_in     = r_svc_in;
    assign o_mpx_request_in     = r_req_in;
    assign o_mpx_data_in        = 1'b0;
    assign o_mpx_disc_in        = 1'b0;
    assign o_state              = r_state;
    assign o_sense              = r_sense;

endmodule

// File: tb/tb_x2050mpxcu.sv
// Directed bench for x2050mpxcu: a vector table for a full read burst plus
// hand sequences for write, stop, errors, sense, stacking, aborts and resets.
module tb_x2050mpxcu;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] bus_out;
    logic       opl_out, sel_out, hold_out, adr_out, cmd_out, svc_out, sup_out;
    logic [8:0] bus_in;
    logic       opl_in, sel_in, adr_in, sta_in, svc_in, req_in, data_in, disc_in;
    logic [3:0] state;
    logic [7:0] sense;

    int nvec = 0;
    int nerr = 0;
    logic [7:0] model [16];

    // inputs {sel, hold, adr, cmd, svc}
    localparam logic [4:0] I_NONE = 5'b00000, I_SELADR = 5'b11100, I_SEL = 5'b11000,
                           I_SELCMD = 5'b11010, I_SELSVC = 5'b11001,
                           I_SVC = 5'b00001, I_CMD = 5'b00010;
    // expected in-tags {opl, sel, addr, sta, svc, req}
    localparam logic [5:0] E_NONE = 6'b000000, E_ADDR = 6'b101000, E_OPL = 6'b100000,
                           E_STA = 6'b100100, E_SVC = 6'b100010, E_PASS = 6'b010000,
                           E_REQ = 6'b000001;

    typedef struct {
        logic [4:0] tin;
        logic [8:0] bus;
        logic [5:0] etag;
        logic [8:0] ebus;
    } vec_t;
    vec_t tbl[$];

    x2050mpxcu dut (
        .i_clk                 (clk),
        .i_reset               (rst),
        .i_mpx_bus_out         (bus_out),
        .i_mpx_operational_out (opl_out),
        .i_mpx_select_out      (sel_out),
        .i_mpx_hold_out        (hold_out),
        .i_mpx_address_out     (adr_out),
        .i_mpx_command_out     (cmd_out),
        .i_mpx_service_out     (svc_out),
        .i_mpx_suppress_out    (sup_out),
        .o_mpx_bus_in          (bus_in),
        .o_mpx_operational_in  (opl_in),
        .o_mpx_select_in       (sel_in),
        .o_mpx_address_in      (adr_in),
        .o_mpx_status_in       (sta_in),
        .o_mpx_service_in      (svc_in),
        .o_mpx_request_in      (req_in),
        .o_mpx_data_in         (data_in),
        .o_mpx_disc_in         (disc_in),
        .o_state               (state),
        .o_sense               (sense)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] par(input logic [7:0] b);
        return {~^b, b};
    endfunction

    task automatic cyc(input logic [4:0] tin, input logic [8:0] bus);
        {sel_out, hold_out, adr_out, cmd_out, svc_out} = tin;
        bus_out = bus;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [5:0] et, input logic [8:0] eb);
        logic [7:0] gt;
        gt = {opl_in, sel_in, adr_in, sta_in, svc_in, req_in, data_in, disc_in};
        nvec++;
        if (gt !== {et, 2'b00} || bus_in !== eb) begin
            nerr++;
            $display("FAIL %s: tags %b bus %h, expected tags %b bus %h",
                     nm, gt, bus_in, {et, 2'b00}, eb);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] got, input logic [7:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Select DEV_ADDR, issue a command and check the initial status.
    task automatic start(input logic [7:0] c, input logic [7:0] istat, input logic badp);
        cyc(I_SELADR, par(8'h0E));
        chk("addr_in", E_ADDR, par(8'h0E));
        cyc(I_SELCMD, badp ? (par(c) ^ 9'h100) : par(c));
        chk("cmd_latch", E_OPL, 9'h000);
        cyc(I_SEL, 9'h000);
        chk("init_status", E_STA, par(istat));
    endtask

    task automatic end_istat();
        cyc(I_SELSVC, 9'h000);
        chk("istat_accept", E_OPL, 9'h000);
        cyc(I_NONE, 9'h000);
        chk("istat_end", E_NONE, 9'h000);
    endtask

    task automatic xfer(input int n, input logic wr, input logic sns,
                        input logic [7:0] sval, input logic [7:0] wbase);
        for (int i = 0; i < n; i++) begin
            cyc(I_SEL, 9'h000);
            chk("svc_in", E_SVC, wr ? 9'h000 : (sns ? par(sval) : par(model[i])));
            cyc(I_SELSVC, wr ? par(wbase + 8'(i)) : 9'h000);
            chk("svc_drop", E_OPL, 9'h000);
            if (wr) model[i] = wbase + 8'(i);
        end
    endtask

    task automatic finish_estat();
        cyc(I_SEL, 9'h000);
        chk("end_status", E_STA, par(8'h0C));
        cyc(I_SVC, 9'h000);
        chk("end_accept", E_NONE, 9'h000);
    endtask

    task automatic run_cmd(input logic [7:0] c, input int n, input logic [7:0] wbase,
                           input logic [7:0] sval);
        start(c, 8'h00, 1'b0);
        cyc(I_SELSVC, 9'h000);
        chk("istat_accept", E_OPL, 9'h000);
        xfer(n, c == 8'h01, c == 8'h04, sval, wbase);
        finish_estat();
    endtask

    initial begin
        rst = 1'b1; opl_out = 1'b1; sup_out = 1'b0;
        {sel_out, hold_out, adr_out, cmd_out, svc_out} = I_NONE;
        bus_out = 9'h000;
        for (int i = 0; i < 16; i++) model[i] = 8'h40 + 8'(i);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_tags", E_NONE, 9'h000);
        chk8("reset_state", {4'h0, state}, 8'h00);
        chk8("reset_sense", sense, 8'h00);
        rst = 1'b0;
        cyc(I_NONE, 9'h000);
        chk("idle", E_NONE, 9'h000);

        // Table: read command over the seeded buffer.
        tbl.push_back('{I_SELADR, par(8'h0E), E_ADDR, par(8'h0E)});
        tbl.push_back('{I_SELCMD, par(8'h02), E_OPL, 9'h000});
        tbl.push_back('{I_SEL, 9'h000, E_STA, par(8'h00)});
        tbl.push_back('{I_SELSVC, 9'h000, E_OPL, 9'h000});
        for (int i = 0; i < 16; i++) begin
            tbl.push_back('{I_SEL, 9'h000, E_SVC, par(8'h40 + 8'(i))});
            tbl.push_back('{I_SELSVC, 9'h000, E_OPL, 9'h000});
        end
        tbl.push_back('{I_SEL, 9'h000, E_STA, par(8'h0C)});
        tbl.push_back('{I_SVC, 9'h000, E_NONE, 9'h000});
        tbl.push_back('{I_NONE, 9'h000, E_NONE, 9'h000});
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].tin, tbl[i].bus);
            chk("table_read", tbl[i].etag, tbl[i].ebus);
        end

        // Write A0..AF, read back, then stop a read after four bytes.
        run_cmd(8'h01, 16, 8'hA0, 8'h00);
        run_cmd(8'h02, 16, 8'h00, 8'h00);
        start(8'h02, 8'h00, 1'b0);
        cyc(I_SELSVC, 9'h000);
        chk("istat_accept", E_OPL, 9'h000);
        xfer(4, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc(I_SEL, 9'h000);
        chk("stop_byte4", E_SVC, par(model[4]));
        cyc(I_SELCMD, 9'h000);
        chk("stop_cmd", E_OPL, 9'h000);
        finish_estat();

        // Invalid command, abort mid-read keeps sense, sense then clears.
        start(8'h07, 8'h0E, 1'b0);
        end_istat();
        chk8("sense_reject", sense, 8'h80);
        start(8'h02, 8'h00, 1'b0);
        cyc(I_SELSVC, 9'h000);
        chk("istat_accept", E_OPL, 9'h000);
        cyc(I_SEL, 9'h000);
        chk("abort_data", E_SVC, par(model[0]));
        cyc(I_NONE, 9'h000);
        chk("abort_idle", E_NONE, 9'h000);
        chk8("abort_sense", sense, 8'h80);
        run_cmd(8'h04, 1, 8'h00, 8'h80);
        run_cmd(8'h04, 1, 8'h00, 8'h00);

        // Foreign address passes select through.
        cyc(I_SELADR, par(8'h0F));
        chk("pass_sel", E_PASS, 9'h000);
        cyc(I_SEL, 9'h000);
        chk("pass_hold", E_PASS, 9'h000);
        cyc(I_NONE, 9'h000);
        chk("pass_drop", E_NONE, 9'h000);

        // Bad bus-out parity on the command byte.
        start(8'h03, 8'h0E, 1'b1);
        end_istat();
        chk8("sense_busout", sense, 8'h20);
        run_cmd(8'h04, 1, 8'h00, 8'h20);

        // Stack ending status, busy reply while pending, then poll.
        start(8'h02, 8'h00, 1'b0);
        cyc(I_SELSVC, 9'h000);
        chk("istat_accept", E_OPL, 9'h000);
        xfer(1, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc(I_SEL, 9'h000);
        chk("stk_data", E_SVC, par(model[1]));
        cyc(I_SELCMD, 9'h000);
        chk("stk_stop", E_OPL, 9'h000);
        cyc(I_SEL, 9'h000);
        chk("stk_estat", E_STA, par(8'h0C));
        cyc(I_CMD, 9'h000);
        chk("stk_drop", E_NONE, 9'h000);
        cyc(I_NONE, 9'h000);
        chk("stk_request", E_REQ, 9'h000);
        start(8'h02, 8'h10, 1'b0);
        end_istat();
        cyc(I_NONE, 9'h000);
        chk("busy_request", E_REQ, 9'h000);
        cyc(I_SEL, 9'h000);
        chk("poll_addr", E_ADDR, par(8'h0E));
        cyc(I_SELCMD, 9'h000);
        chk("poll_proceed", E_OPL, 9'h000);
        finish_estat();
        cyc(I_NONE, 9'h000);
        chk("poll_cleared", E_NONE, 9'h000);

        // Operational-out drop mid-read: idle, buffer intact.
        start(8'h02, 8'h00, 1'b0);
        cyc(I_SELSVC, 9'h000);
        chk("istat_accept", E_OPL, 9'h000);
        xfer(2, 1'b0, 1'b0, 8'h00, 8'h00);
        opl_out = 1'b0;
        cyc(I_SEL, 9'h000);
        chk("opl_drop", E_NONE, 9'h000);
        chk8("opl_state", {4'h0, state}, 8'h00);
        opl_out = 1'b1;
        cyc(I_NONE, 9'h000);
        run_cmd(8'h02, 16, 8'h00, 8'h00);

        // Asynchronous reset during data transfer reseeds the buffer.
        start(8'h02, 8'h00, 1'b0);
        cyc(I_SELSVC, 9'h000);
        chk("istat_accept", E_OPL, 9'h000);
        cyc(I_SEL, 9'h000);
        chk("rst_data", E_SVC, par(model[0]));
        #2;
        {sel_out, hold_out, adr_out, cmd_out, svc_out} = I_NONE;
        rst = 1'b1;
        #1;
        chk("async_reset", E_NONE, 9'h000);
        chk8("async_state", {4'h0, state}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h40 + 8'(i);
        cyc(I_NONE, 9'h000);
        run_cmd(8'h02, 16, 8'h00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
